// File: rtl/lcd_refresh_engine_if.sv
// ---------------------------------------------------------------------------
// lcd_refresh_engine_if
//
// Purpose: the 8-bit write-only HD44780-style LCD pin bundle that runs between
// the refresh engine and the board pins.
//
// Signals:
//   LCD_DATA  8  data/command byte
//   LCD_RS    1  0 = command, 1 = character data
//   LCD_RW    1  read/write select, always 0 (the bus is write-only)
//   LCD_EN    1  enable strobe; the panel latches LCD_DATA while it is high
//
// Modports:
//   master  the engine, which drives every pin
//   slave   the panel side, which only observes
// ---------------------------------------------------------------------------
interface lcd_refresh_engine_if;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;

    modport master (output LCD_DATA, output LCD_RS, output LCD_RW, output LCD_EN);
    modport slave  (input  LCD_DATA, input  LCD_RS, input  LCD_RW, input  LCD_EN);
endinterface

// File: rtl/lcd_refresh_engine.sv
// ---------------------------------------------------------------------------
// lcd_refresh_engine
//
// Purpose: drives a ROWS x COLS character LCD over an 8-bit write-only bus.
// After reset it sends the panel init commands, then repeatedly writes whole
// frames taken from a snapshot of iCHARS latched at the start of each frame.
// A refresh request that arrives mid-frame is remembered (at most one) and
// served right after the current frame.
//
// Every byte is one write: 1 setup cycle (EN low), CLK_DIV strobe cycles
// (EN high), then a settle period (EN low, data held) of SETTLE cycles, or
// CLR_SETTLE cycles after the clear-display command.
//
// Ports:
//   iCLK      in   system clock
//   iRST_N    in   asynchronous active-low reset
//   iCHARS    in   ROWS*COLS ASCII bytes, row 0 col 0 in the MSB byte
//   iREFRESH  in   one-cycle request for a new frame
//   oBUSY     out  high while initialising or writing a frame
//   oDONE     out  one-cycle pulse once the last write of a frame has settled
//   lcd       if   LCD pin bundle (master side)
//
// Optional build macro: LCD_CHANGE_DETECT_EN
//   When defined, an idle engine also starts a frame by itself as soon as
//   iCHARS differs from the last snapshot (one cycle later than iREFRESH,
//   because the comparison is registered). When undefined, no comparator
//   exists.
// ---------------------------------------------------------------------------
module lcd_refresh_engine #(
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int CLK_DIV    = 16,
    parameter int SETTLE     = 262143,
    parameter int CLR_SETTLE = 262143
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [ROWS*COLS*8-1:0] iCHARS,
    input  logic                   iREFRESH,
    output logic                   oBUSY,
    output logic                   oDONE,
    lcd_refresh_engine_if.master   lcd
);
    localparam int NCHARS = ROWS * COLS;
    localparam int MAXA   = (CLK_DIV > SETTLE) ? CLK_DIV : SETTLE;
    localparam int MAXCNT = (MAXA > CLR_SETTLE) ? MAXA : CLR_SETTLE;
    localparam int CW     = $clog2(MAXCNT + 1);
    localparam int COLW   = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ROWADDR, ST_CHAR, ST_DONE} state_t;
    typedef enum logic [1:0] {PH_LOAD, PH_SETUP, PH_STROBE, PH_SETTLE} phase_t;

    state_t                 state_q;
    phase_t                 phase_q;
    logic [CW-1:0]          cnt_q;
    logic [1:0]             initIdx_q;
    logic [1:0]             row_q;
    logic [COLW-1:0]        col_q;
    logic                   pending_q;
    logic [NCHARS*8-1:0]    snap_q;
    logic [7:0]             data_q;
    logic                   rs_q;
    logic                   en_q;
    logic                   busy_q;
    logic                   done_q;

    logic writeEnd;
    logic lastCol;
    logic lastRow;
    logic changeHit;
    logic startFrame;
    logic busyReq;

    function automatic logic [7:0] initCmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Set-DDRAM-address command for the first column of each row.
    function automatic logic [7:0] rowCmd(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h94;
            default: return 8'hD4;
        endcase
    endfunction

    function automatic logic [7:0] charAt(input logic [NCHARS*8-1:0] frame,
                                          input int row, input int col);
        int pos;
        pos = (NCHARS - 1) - (row * COLS + col);
        return frame[pos*8 +: 8];
    endfunction

    // Optional idle-time change detector; the registered compare keeps the
    // wide equality off the FSM's critical path.
`ifdef LCD_CHANGE_DETECT_EN
    logic diff_d;
    logic diff_q;
    assign diff_d = (iCHARS != snap_q);
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            diff_q <= 1'b0;
        end else begin
            diff_q <= diff_d;
        end
    end
    assign changeHit = diff_q;
`else
    assign changeHit = 1'b0;
`endif

    assign writeEnd = (phase_q == PH_SETTLE) && (cnt_q == '0);
    assign lastCol  = (col_q == COLW'(COLS - 1));
    assign lastRow  = (row_q == 2'(ROWS - 1));

    // A frame starts straight after init, from IDLE on request/change, or
    // from DONE when a request is pending or arrives in that very cycle.
    assign startFrame = ((state_q == ST_INIT) && writeEnd && (initIdx_q == 2'd3))
                     || ((state_q == ST_IDLE) && (iREFRESH || changeHit))
                     || ((state_q == ST_DONE) && (pending_q || iREFRESH));

    assign busyReq = iREFRESH && ((state_q == ST_INIT) || (state_q == ST_ROWADDR)
                                  || (state_q == ST_CHAR));

    // Main sequencer. The state selects which byte comes next; the phase
    // walks each byte through setup, strobe and settle. All pins come
    // straight from registers so the bus never glitches.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= ST_INIT;
            phase_q   <= PH_LOAD;
            cnt_q     <= '0;
            initIdx_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pending_q <= 1'b0;
            snap_q    <= '0;
            data_q    <= '0;
            rs_q      <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // DONE always consumes the pending request, either by starting
            // the next frame or because none was waiting.
            if (state_q == ST_DONE) begin
                pending_q <= 1'b0;
            end else if (busyReq) begin
                pending_q <= 1'b1;
            end

            if (startFrame) begin
                snap_q  <= iCHARS;
                state_q <= ST_ROWADDR;
                row_q   <= '0;
                col_q   <= '0;
                data_q  <= rowCmd(2'd0);
                rs_q    <= 1'b0;
                en_q    <= 1'b0;
                phase_q <= PH_SETUP;
                busy_q  <= 1'b1;
            end else begin
                case (phase_q)
                    PH_LOAD: begin
                        if (state_q == ST_INIT) begin
                            data_q  <= initCmd(initIdx_q);
                            rs_q    <= 1'b0;
                            phase_q <= PH_SETUP;
                        end
                    end
                    PH_SETUP: begin
                        en_q    <= 1'b1;
                        cnt_q   <= CW'(CLK_DIV - 1);
                        phase_q <= PH_STROBE;
                    end
                    PH_STROBE: begin
                        if (cnt_q == '0) begin
                            en_q    <= 1'b0;
                            phase_q <= PH_SETTLE;
                            cnt_q   <= (!rs_q && data_q == 8'h01) ? CW'(CLR_SETTLE - 1)
                                                                  : CW'(SETTLE - 1);
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    PH_SETTLE: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CW'(1);
                        end else begin
                            case (state_q)
                                ST_INIT: begin
                                    initIdx_q <= initIdx_q + 2'd1;
                                    data_q    <= initCmd(initIdx_q + 2'd1);
                                    phase_q   <= PH_SETUP;
                                end
                                ST_ROWADDR: begin
                                    state_q <= ST_CHAR;
                                    col_q   <= '0;
                                    data_q  <= charAt(snap_q, int'(row_q), 0);
                                    rs_q    <= 1'b1;
                                    phase_q <= PH_SETUP;
                                end
                                ST_CHAR: begin
                                    if (lastCol && lastRow) begin
                                        state_q <= ST_DONE;
                                        done_q  <= 1'b1;
                                        phase_q <= PH_LOAD;
                                    end else if (lastCol) begin
                                        row_q   <= row_q + 2'd1;
                                        state_q <= ST_ROWADDR;
                                        data_q  <= rowCmd(row_q + 2'd1);
                                        rs_q    <= 1'b0;
                                        phase_q <= PH_SETUP;
                                    end else begin
                                        col_q   <= col_q + COLW'(1);
                                        data_q  <= charAt(snap_q, int'(row_q), int'(col_q) + 1);
                                        phase_q <= PH_SETUP;
                                    end
                                end
                                default: phase_q <= PH_LOAD;
                            endcase
                        end
                    end
                    default: phase_q <= PH_LOAD;
                endcase

                if (state_q == ST_DONE) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    assign lcd.LCD_DATA = data_q;
    assign lcd.LCD_RS   = rs_q;
    assign lcd.LCD_RW   = 1'b0;
    assign lcd.LCD_EN   = en_q;
    assign oBUSY        = busy_q;
    assign oDONE        = done_q;
endmodule

// File: tb/tb_lcd_refresh_engine.sv
// ---------------------------------------------------------------------------
// tb_lcd_refresh_engine
//
// Purpose: directed self-checking bench for lcd_refresh_engine. Instance u1
// is the 2x4 panel used for most steps; u2 is a 4x2 panel used to look at
// the row-address commands of a four-row display. Bus monitors record every
// write (RS and byte at the EN rising edge), strobe lengths and oDONE pulses.
// Honours LCD_CHANGE_DETECT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_lcd_refresh_engine;
    localparam int CLK_DIV    = 2;
    localparam int SETTLE     = 3;
    localparam int CLR_SETTLE = 5;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [63:0] chars1;
    logic [63:0] chars2;
    logic        refresh1;
    logic        refresh2;
    logic        busy1, done1, busy2, done2;

    lcd_refresh_engine_if bus1 ();
    lcd_refresh_engine_if bus2 ();

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected full bus sequence after reset for u1, {RS, byte}.
    logic [8:0] expBoot [14] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080, 9'h141, 9'h142,
                                 9'h143, 9'h144, 9'h0C0, 9'h145, 9'h146, 9'h147, 9'h148};
    // EN rising-edge spacing: 1+2+3 normally, 1+2+5 after the clear command.
    int expGap [13] = '{6, 6, 8, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6};
    // Expected bus sequence for the 4x2 panel with "ABCDEFGH".
    logic [8:0] expFour [16] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080, 9'h141, 9'h142,
                                 9'h0C0, 9'h143, 9'h144, 9'h094, 9'h145, 9'h146,
                                 9'h0D4, 9'h147, 9'h148};

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    lcd_refresh_engine #(.COLS(4), .ROWS(2), .CLK_DIV(CLK_DIV), .SETTLE(SETTLE),
                         .CLR_SETTLE(CLR_SETTLE)) u1 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCHARS(chars1), .iREFRESH(refresh1),
        .oBUSY(busy1), .oDONE(done1), .lcd(bus1));

    lcd_refresh_engine #(.COLS(2), .ROWS(4), .CLK_DIV(CLK_DIV), .SETTLE(SETTLE),
                         .CLR_SETTLE(CLR_SETTLE)) u2 (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCHARS(chars2), .iREFRESH(refresh2),
        .oBUSY(busy2), .oDONE(done2), .lcd(bus2));

    // Monitor for u1: logs each write, strobe length, and oDONE activity.
    logic [8:0] wr [$];
    int         wrRise [$];
    int         enLen [$];
    int         highRun   = 0;
    int         doneCount = 0;
    int         doneHigh  = 0;
    int         doneCyc   = 0;
    logic       prevEn    = 1'b0;
    logic       prevDone  = 1'b0;

    always @(negedge iCLK) begin
        if (!iRST_N) begin
            prevEn   <= 1'b0;
            prevDone <= 1'b0;
            highRun  <= 0;
        end else begin
            if (bus1.LCD_EN && !prevEn) begin
                wr.push_back({bus1.LCD_RS, bus1.LCD_DATA});
                wrRise.push_back(cyc);
                highRun <= 1;
            end else if (bus1.LCD_EN) begin
                highRun <= highRun + 1;
            end
            if (!bus1.LCD_EN && prevEn) enLen.push_back(highRun);
            if (done1) doneHigh <= doneHigh + 1;
            if (done1 && !prevDone) begin
                doneCount <= doneCount + 1;
                doneCyc   <= cyc;
            end
            prevEn   <= bus1.LCD_EN;
            prevDone <= done1;
        end
    end

    // Monitor for u2: only the write sequence and frame completions matter.
    logic [8:0] wr2 [$];
    int         done2Count = 0;
    logic       prevEn2    = 1'b0;

    always @(negedge iCLK) begin
        if (!iRST_N) begin
            prevEn2 <= 1'b0;
        end else begin
            if (bus2.LCD_EN && !prevEn2) wr2.push_back({bus2.LCD_RS, bus2.LCD_DATA});
            if (done2) done2Count <= done2Count + 1;
            prevEn2 <= bus2.LCD_EN;
        end
    end

    task automatic tick();
        @(negedge iCLK);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the character bus and optionally pulse iREFRESH for one cycle.
    task automatic applyStimulus(input logic [63:0] chars, input logic pulse);
        chars1   = chars;
        refresh1 = pulse;
        tick();
        refresh1 = 1'b0;
    endtask

    task automatic waitDone(input int target, input int bound);
        int n;
        n = 0;
        while (doneCount < target && n < bound) begin
            tick();
            n++;
        end
        checkOutput("doneReached", 32'(doneCount >= target), 1);
    endtask

    task automatic waitIdle(input int bound);
        int n;
        int run;
        n   = 0;
        run = 0;
        while (run < 3 && n < bound) begin
            tick();
            n++;
            run = busy1 ? 0 : run + 1;
        end
        checkOutput("idleReached", 32'(run >= 3), 1);
    endtask

    task automatic waitWrites(input int target, input int bound);
        int n;
        n = 0;
        while (wr.size() < target && n < bound) begin
            tick();
            n++;
        end
        checkOutput("writesReached", 32'(wr.size() >= target), 1);
    endtask

    // Compare one 2x4 frame (10 writes starting at base) against chars.
    task automatic checkFrame(input string tag, input int base, input logic [63:0] chars);
        logic [8:0] exp;
        for (int r = 0; r < 2; r++) begin
            exp = (r == 0) ? 9'h080 : 9'h0C0;
            checkOutput({tag, "_rowCmd"}, 32'(wr[base + r*5]), 32'(exp));
            for (int c = 0; c < 4; c++) begin
                exp = {1'b1, chars[(7 - (r*4 + c))*8 +: 8]};
                checkOutput({tag, "_char"}, 32'(wr[base + r*5 + 1 + c]), 32'(exp));
            end
        end
    endtask

    initial begin
        int base;
        int d0;
        int dh0;
        int n;
        int busyLow;
        logic found;

        iRST_N   = 1'b0;
        chars1   = "ABCDEFGH";
        chars2   = "ABCDEFGH";
        refresh1 = 1'b0;
        refresh2 = 1'b0;
        tick();
        tick();

        // Values held while reset is asserted.
        checkOutput("rstData", 32'(bus1.LCD_DATA), 0);
        checkOutput("rstRs",   32'(bus1.LCD_RS), 0);
        checkOutput("rstRw",   32'(bus1.LCD_RW), 0);
        checkOutput("rstEn",   32'(bus1.LCD_EN), 0);
        checkOutput("rstBusy", 32'(busy1), 1);
        checkOutput("rstDone", 32'(done1), 0);
        checkOutput("rstBusy2", 32'(busy2), 1);

        // Boot: init commands, then the automatic first frame.
        iRST_N = 1'b1;
        waitDone(1, 1000);
        checkOutput("bootWrites", wr.size(), 14);
        for (int i = 0; i < 14; i++) checkOutput("bootSeq", 32'(wr[i]), 32'(expBoot[i]));
        for (int i = 0; i < 14; i++) checkOutput("bootEnLen", enLen[i], CLK_DIV);
        for (int i = 0; i < 13; i++) checkOutput("bootGap", wrRise[i+1] - wrRise[i], expGap[i]);
        checkOutput("frameCycles", doneCyc - wrRise[4], 59);
        tick();
        checkOutput("idleBusy", 32'(busy1), 0);
        checkOutput("idleDone", 32'(done1), 0);
        tick();
        checkOutput("bootDoneCount", doneCount, 1);
        checkOutput("bootDoneWidth", doneHigh, 1);

        // Four-row panel: row address commands 0x80, 0xC0, 0x94, 0xD4.
        n = 0;
        while (done2Count < 1 && n < 1000) begin
            tick();
            n++;
        end
        checkOutput("fourDone", done2Count, 1);
        checkOutput("fourWrites", wr2.size(), 16);
        for (int i = 0; i < 16; i++) checkOutput("fourSeq", 32'(wr2[i]), 32'(expFour[i]));

        // Snapshot: characters changed during the 2nd write do not leak in.
        waitIdle(500);
        base = wr.size();
        d0   = doneCount;
        applyStimulus("ABCDEFGH", 1'b1);
        waitWrites(base + 2, 100);
        applyStimulus("WXYZ1234", 1'b0);
        waitDone(d0 + 1, 500);
        checkOutput("snapWrites", wr.size() - base, 10);
        checkFrame("snapOld", base, "ABCDEFGH");
        waitIdle(500);
        base = wr.size();
        d0   = doneCount;
        applyStimulus("WXYZ1234", 1'b1);
        waitDone(d0 + 1, 500);
        checkOutput("snapNewWrites", wr.size() - base, 10);
        checkFrame("snapNew", base, "WXYZ1234");

        // Three requests during a frame collapse into one extra frame.
        waitIdle(500);
        base    = wr.size();
        d0      = doneCount;
        dh0     = doneHigh;
        busyLow = 0;
        applyStimulus(chars1, 1'b1);
        tick();
        tick();
        applyStimulus(chars1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(chars1, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        applyStimulus(chars1, 1'b1);
        n = 0;
        while (doneCount < d0 + 2 && n < 500) begin
            if (!busy1) busyLow++;
            tick();
            n++;
        end
        checkOutput("pendTwoDone", doneCount - d0, 2);
        checkOutput("pendBusyHeld", busyLow, 0);
        waitIdle(500);
        for (int i = 0; i < 40; i++) tick();
        checkOutput("pendNoThird", doneCount - d0, 2);
        checkOutput("pendDoneWidth", doneHigh - dh0, 2);
        checkOutput("pendWrites", wr.size() - base, 20);
        checkFrame("pendSecond", base + 10, "WXYZ1234");

        // Reset during the strobe of 'C'.
        waitIdle(500);
        applyStimulus("ABCDEFGH", 1'b1);
        found = 1'b0;
        n     = 0;
        while (!found && n < 200) begin
            tick();
            n++;
            found = bus1.LCD_EN && bus1.LCD_RS && (bus1.LCD_DATA == 8'h43);
        end
        checkOutput("reachStrobeC", 32'(found), 1);
        iRST_N = 1'b0;
        #1;
        checkOutput("midRstEn",   32'(bus1.LCD_EN), 0);
        checkOutput("midRstData", 32'(bus1.LCD_DATA), 0);
        checkOutput("midRstRs",   32'(bus1.LCD_RS), 0);
        checkOutput("midRstBusy", 32'(busy1), 1);
        checkOutput("midRstDone", 32'(done1), 0);
        tick();
        tick();
        base   = wr.size();
        d0     = doneCount;
        iRST_N = 1'b1;
        waitWrites(base + 1, 50);
        checkOutput("restartCmd", 32'(wr[base]), 32'h038);
        waitDone(d0 + 1, 1000);
        checkOutput("restartWrites", wr.size() - base, 14);
        checkFrame("restartFrame", base + 4, "ABCDEFGH");
        waitIdle(500);

        // Idle character change without iREFRESH.
        base = wr.size();
        d0   = doneCount;
        applyStimulus("WXYZ1234", 1'b0);
        tick();
`ifdef LCD_CHANGE_DETECT_EN
        checkOutput("changeStart", 32'(busy1), 1);
        waitDone(d0 + 1, 500);
        checkFrame("changeFrame", base, "WXYZ1234");
`else
        checkOutput("changeNoStart", 32'(busy1), 0);
        for (int i = 0; i < 30; i++) tick();
        checkOutput("changeNoWrites", wr.size() - base, 0);
        checkOutput("changeStillIdle", 32'(busy1), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
